// File: rtl/iob_sio_hdx.sv
// Half-duplex single-wire UART-style transceiver on the core side of a 3-state pad.
// Direction turnaround (driven-high preamble, post-TX blind guard) is sequenced internally.
module iob_sio_hdx #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int TA_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_err,
    output logic              rx_ovr,
    output logic              busy,
    output logic              pad_i,
    output logic              pad_t,
    input  logic              pad_o
);

    localparam int BIT_W = $clog2(DATA_W + 2);
    localparam logic [DIV_W-1:0] DIV_MIN     = DIV_W'(4);
    localparam logic [DIV_W-1:0] TA_LAST     = DIV_W'(TA_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_STOP_RX = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_STOP_TX = BIT_W'(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_TA    = 3'd1,
        TX_BITS  = 3'd2,
        TX_GUARD = 3'd3,
        RX_START = 3'd4,
        RX_BITS  = 3'd5
    } state_t;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        logic [DIV_W-1:0] r;
        if (d < DIV_MIN) begin
            r = DIV_MIN;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Line level for TX frame slot idx: 0 = start, 1..DATA_W = data LSB first, then stop.
    function automatic logic tx_bit_val(input logic [BIT_W-1:0] idx, input logic [DATA_W-1:0] data);
        logic v;
        v = 1'b1;
        if (idx == '0) begin
            v = 1'b0;
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (idx == BIT_W'(i + 1)) begin
                    v = data[i];
                end else begin
                    v = v;
                end
            end
        end
        return v;
    endfunction

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_err_q, rx_err_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              pad_t_q, pad_t_d;
    logic              pad_i_q, pad_i_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              line_prev_q, line_prev_d;

    logic              fall_s;
    logic              fall_next_s;
    logic [DIV_W-1:0]  div_last_s;
    logic [DIV_W-1:0]  half_last_s;

    assign fall_s      = line_prev_q & ~sync2_q;
    // The edge IDLE will see next cycle is already visible in the synchronizer chain.
    assign fall_next_s = sync2_q & ~sync1_q;
    assign div_last_s  = div_q - DIV_W'(1);
    assign half_last_s = (div_q >> 1) - DIV_W'(1);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        div_d       = div_q;
        tx_buf_d    = tx_buf_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_err_d    = 1'b0;
        rx_ovr_d    = 1'b0;
        sync1_d     = pad_o;
        sync2_d     = sync1_q;
        line_prev_d = sync2_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (fall_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                    div_d   = clamp_div(div);
                end else if (tx_valid && tx_ready_q) begin
                    state_d  = TX_TA;
                    cnt_d    = '0;
                    tx_buf_d = tx_data;
                    div_d    = clamp_div(div);
                end else begin
                    state_d = IDLE;
                end
            end
            TX_TA: begin
                if (cnt_q == TA_LAST) begin
                    state_d = TX_BITS;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            TX_BITS: begin
                if (cnt_q == div_last_s) begin
                    cnt_d = '0;
                    if (bit_q == BIT_STOP_TX) begin
                        state_d = TX_GUARD;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            TX_GUARD: begin
                if (cnt_q == TA_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            RX_START: begin
                if (cnt_q == half_last_s) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (sync2_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RX_BITS;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            RX_BITS: begin
                if (cnt_q == div_last_s) begin
                    cnt_d = '0;
                    if (bit_q == BIT_STOP_RX) begin
                        state_d = IDLE;
                        // A consumer draining the old byte this cycle frees the slot for the new one.
                        if (!sync2_q) begin
                            rx_err_d = 1'b1;
                        end else if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_ovr_d = 1'b1;
                        end
                    end else begin
                        rx_shift_d = {sync2_q, rx_shift_q[DATA_W-1:1]};
                        bit_d      = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        pad_t_d    = !((state_d == TX_TA) || (state_d == TX_BITS));
        busy_d     = (state_d != IDLE);
        tx_ready_d = (state_d == IDLE) && !fall_next_s;
        if (state_d == TX_BITS) begin
            pad_i_d = tx_bit_val(bit_d, tx_buf_d);
        end else begin
            pad_i_d = 1'b1;
        end
    end

    // State and output registers; reset releases the pad immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            div_q       <= DIV_MIN;
            tx_buf_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            pad_t_q     <= 1'b1;
            pad_i_q     <= 1'b1;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            tx_buf_q    <= tx_buf_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            pad_t_q     <= pad_t_d;
            pad_i_q     <= pad_i_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            line_prev_q <= line_prev_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign rx_ovr   = rx_ovr_q;
    assign busy     = busy_q;
    assign pad_i    = pad_i_q;
    assign pad_t    = pad_t_q;

endmodule
